// File: rtl/attack_sequencer_if.sv
// Player-input / animation bus for one fighter's attack sequencer.
// The master side (input block) drives buttons and frame timing.
// The slave side (sequencer) drives the animation and hitbox controls.
interface attack_sequencer_if;
  logic       frame_tick;
  logic       btn_atk;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       hit_stun_active;
  logic       attack_active;
  logic       hitbox_en;
  logic [1:0] attack_type;
  logic [3:0] anim_ID;
  logic [2:0] phase;

  modport master (
    output frame_tick, btn_atk, btn_up, btn_down, btn_left, btn_right, hit_stun_active,
    input  attack_active, hitbox_en, attack_type, anim_ID, phase
  );

  modport slave (
    input  frame_tick, btn_atk, btn_up, btn_down, btn_left, btn_right, hit_stun_active,
    output attack_active, hitbox_en, attack_type, anim_ID, phase
  );
endinterface

// File: rtl/attack_sequencer.sv
// Frame-counted attack controller: startup -> active -> recovery -> cooldown.
// Supports a one-deep input buffer during recovery/cooldown and hit-stun abort.
// All outputs are decoded from registered state only.
module attack_sequencer #(
  parameter int unsigned STARTUP_FRAMES  = 3,
  parameter int unsigned ACTIVE_FRAMES   = 4,
  parameter int unsigned RECOVERY_FRAMES = 6,
  parameter int unsigned COOLDOWN_FRAMES = 4
) (
  input logic               clk,
  input logic               rst,
  attack_sequencer_if.slave bus_if
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STARTUP  = 3'd1,
    S_ACTIVE   = 3'd2,
    S_RECOVERY = 3'd3,
    S_COOLDOWN = 3'd4
  } phase_e;

  localparam logic [3:0] STARTUP_LD  = 4'(STARTUP_FRAMES);
  localparam logic [3:0] ACTIVE_LD   = 4'(ACTIVE_FRAMES);
  localparam logic [3:0] RECOVERY_LD = 4'(RECOVERY_FRAMES);
  localparam logic [3:0] COOLDOWN_LD = 4'(COOLDOWN_FRAMES);

  phase_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       btn_atk_q;
  logic       buf_q, buf_d;
  logic [1:0] buf_dir_q, buf_dir_d;
  logic [1:0] type_q, type_d;

  logic       req;
  logic       expire;
  logic       in_seq;
  logic [1:0] dir_sel;

  // Request edge, phase-expiry strobe and prioritised direction for this cycle
  always_comb begin
    req    = bus_if.btn_atk & ~btn_atk_q;
    in_seq = (state_q != S_IDLE);
    expire = in_seq & bus_if.frame_tick & (cnt_q == 4'd1);
    if (bus_if.btn_up)                           dir_sel = 2'd1;
    else if (bus_if.btn_down)                    dir_sel = 2'd2;
    else if (bus_if.btn_left | bus_if.btn_right) dir_sel = 2'd3;
    else                                         dir_sel = 2'd0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: hit-stun overrides expiry and requests
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (req && !bus_if.hit_stun_active) state_d = S_STARTUP;
    end else if (bus_if.hit_stun_active) begin
      state_d = S_IDLE;
    end else if (expire) begin
      case (state_q)
        S_STARTUP:  state_d = S_ACTIVE;
        S_ACTIVE:   state_d = S_RECOVERY;
        S_RECOVERY: state_d = S_COOLDOWN;
        S_COOLDOWN: state_d = (buf_q || req) ? S_STARTUP : S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: phase counter, input buffer and latched attack type
  always_comb begin
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    buf_dir_d = buf_dir_q;
    type_d    = type_q;

    if (state_d != state_q) begin
      case (state_d)
        S_STARTUP:  cnt_d = STARTUP_LD;
        S_ACTIVE:   cnt_d = ACTIVE_LD;
        S_RECOVERY: cnt_d = RECOVERY_LD;
        S_COOLDOWN: cnt_d = COOLDOWN_LD;
        default:    cnt_d = 4'd0;
      endcase
    end else if (in_seq && bus_if.frame_tick) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (req && (state_q == S_RECOVERY || state_q == S_COOLDOWN)) begin
      buf_d     = 1'b1;
      buf_dir_d = dir_sel;
    end

    if (state_d == S_STARTUP && state_q != S_STARTUP) begin
      if (state_q == S_IDLE || req) type_d = dir_sel;
      else                          type_d = buf_dir_q;
      buf_d = 1'b0;
    end

    if (bus_if.hit_stun_active) buf_d = 1'b0;
  end

  // Datapath registers; the button history resets high so a held button does not fire
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      btn_atk_q <= 1'b1;
      buf_q     <= 1'b0;
      buf_dir_q <= 2'd0;
      type_q    <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      btn_atk_q <= bus_if.btn_atk;
      buf_q     <= buf_d;
      buf_dir_q <= buf_dir_d;
      type_q    <= type_d;
    end
  end

  // Output decode from registered state
  always_comb begin
    bus_if.phase         = state_q;
    bus_if.attack_active = (state_q == S_STARTUP) || (state_q == S_ACTIVE) ||
                           (state_q == S_RECOVERY);
    bus_if.hitbox_en     = (state_q == S_ACTIVE);
    bus_if.attack_type   = type_q;
    bus_if.anim_ID       = bus_if.attack_active ? (4'd6 + {2'b00, type_q}) : 4'd0;
  end

endmodule

// File: doc/attack_sequencer.md
# attack_sequencer

Clocked attack controller for one fighter. It turns a debounced attack button plus direction buttons into a timed startup → active → recovery → cooldown sequence, counted in game frames. It sits between the player input block and the animation/hitbox logic, driving `anim_ID`, `hitbox_en` and `attack_active`. It supports hit-stun abort and a one-deep input buffer.

## Interface
- `STARTUP_FRAMES`, default 3: frame ticks spent in STARTUP (legal 1..15)
- `ACTIVE_FRAMES`, default 4: frame ticks in ACTIVE (1..15)
- `RECOVERY_FRAMES`, default 6: frame ticks in RECOVERY (1..15)
- `COOLDOWN_FRAMES`, default 4: frame ticks in COOLDOWN (1..15)

Ports:
- `clk` in 1: single system clock
- `rst` in 1: synchronous, active-high reset
- `frame_tick` in 1: one-cycle strobe per game frame
- `btn_atk`, `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: debounced buttons, already synchronous to `clk`
- `hit_stun_active` in 1: fighter is in hit-stun
- `attack_active` out 1: high in STARTUP, ACTIVE and RECOVERY
- `hitbox_en` out 1: high in ACTIVE only
- `attack_type` out 2: 0 neutral, 1 up, 2 down, 3 side; held for the whole sequence
- `anim_ID` out 4: 6/7/8/9 for neutral/up/down/side during attack phases; 0 otherwise
- `phase` out 3: 0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY, 4 COOLDOWN

## Operation
- Attack request is the rising edge of `btn_atk`: `btn_atk` high and the registered `btn_atk_q` low. `btn_atk_q` resets to 1, so a button held through reset does not trigger an attack.
- Direction is sampled on the request cycle with priority up > down > (left | right) > neutral.
  - Left and right together count as side.
  - The sampled value is latched into `attack_type` and held until the next accepted request.
- Phase counter is 4 bits.
  - It loads the phase's parameter on entry to STARTUP, ACTIVE, RECOVERY or COOLDOWN.
  - It decrements on each `frame_tick`.
  - The phase advances on the clock where count == 1 and `frame_tick` is high. Each phase therefore lasts exactly N ticks.
- State transitions:
  - IDLE → STARTUP on request when `hit_stun_active` = 0. A request during hit-stun is dropped, not buffered.
  - STARTUP → ACTIVE → RECOVERY → COOLDOWN on counter expiry.
  - COOLDOWN → STARTUP on expiry if the buffer is set and `hit_stun_active` = 0. This consumes the buffer and latches the buffered direction.
  - COOLDOWN → IDLE on expiry otherwise.
- Buffer (one deep):
  - Set by a request during RECOVERY or COOLDOWN; the direction is sampled at that request.
  - A later request overwrites the buffered direction.
  - Requests during STARTUP or ACTIVE are ignored.
  - Cleared on consumption, on hit-stun, and on reset.
- Hit-stun abort: `hit_stun_active` = 1 in STARTUP, ACTIVE, RECOVERY or COOLDOWN forces IDLE on the next clock and clears the buffer. `attack_type` keeps its last value.
- Simultaneous events:
  - Hit-stun beats counter expiry and beats a request.
  - A request on the same cycle as COOLDOWN expiry counts as buffered and starts STARTUP immediately.
  - Reset beats everything.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- Reset values: `attack_active` = 0, `hitbox_en` = 0, `attack_type` = 0, `anim_ID` = 0, `phase` = 0, buffer = 0, counter = 0, `btn_atk_q` = 1.
- Request latency: `btn_atk` first sampled high at edge t (with `btn_atk_q` = 0) → `phase` = 1 and `attack_active` = 1 are visible after edge t.
- Phase length: N `frame_tick` pulses after entry. A tick on the entry edge itself is not counted.
- Hit-stun abort latency: 1 clock. Reset mid-sequence: IDLE after that edge, all outputs at reset values.
- Counter never underflows: decrement happens only in non-IDLE states, and expiry reloads or exits.

## Test plan
1. Reset with `btn_atk` held, release, wait 10 ticks → `phase` stays 0. Then press with `btn_up` → `attack_type` = 1, `anim_ID` = 7.
2. Neutral press, `frame_tick` every 4 clocks → `phase` sequence 1 (3 ticks), 2 (4 ticks, `hitbox_en` = 1), 3 (6 ticks), 4 (4 ticks), 0. `anim_ID` = 6 in phases 1-3 and 0 in phase 4.
3. Press with left+right+down → `attack_type` = 2. Press with left+right only → `attack_type` = 3, `anim_ID` = 9.
4. Assert `hit_stun_active` on the 2nd ACTIVE tick → next clock `phase` = 0, `hitbox_en` = 0, `attack_active` = 0. A press during hit-stun → no attack.
5. Buffer:
   - Press with `btn_down` during RECOVERY → after COOLDOWN expiry, `phase` goes 4 → 1 with `attack_type` = 2, with no IDLE cycle.
   - Same, but hit-stun during COOLDOWN → buffer dropped, `phase` = 0.
6. Press on the COOLDOWN expiry cycle → STARTUP on the next clock. Press during STARTUP → ignored; sequence ends in IDLE.
